uart_cmd_decoder: RTL and testbench

- Byte-level command decoder between the UART byte receiver/transmitter and the TPU memory/control port (addr, write data, write enable, start, read data, busy/done).
- Turns a simple packet protocol into one-cycle memory write strobes, paced read-back streams, TPU start pulses and status responses.
- Replaces ad-hoc byte handling so UART mode gets framed, length-checked, timeout-protected transfers.

---
 rtl/uart_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Byte-packet decoder from UART rx/tx to the TPU memory/control port. mem_we one cycle after the
// last write byte, response tx_valid two cycles after; tx_valid holds until tx_ready, busy-time rx bytes are dropped.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       tpu_start,
    input  logic       tpu_busy,
    input  logic       tpu_done,
    output logic       timeout_err,
    output logic       overrun_err
);

    localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_FETCH, RD_SEND, RESP
    } state_t;

    state_t        state;
    logic          is_write;
    logic [8:0]    count;
    logic [TW-1:0] timer;
    logic          timed;
    logic          busy_tx;

    // Inter-byte timeout only guards states that are waiting on the host.
    assign timed   = (state == GET_ADDR) || (state == GET_LEN) || (state == WR_DATA);
    assign busy_tx = (state == RD_FETCH) || (state == RD_SEND) || (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            count       <= '0;
            timer       <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            tpu_start   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            tpu_start   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;

            // Address advances the cycle after each strobe, wherever the FSM has moved to.
            if (mem_we)
                mem_addr <= mem_addr + 8'd1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        timer <= '0;
                        case (rx_data)
                            8'h57: begin
                                is_write <= 1'b1;
                                state    <= GET_ADDR;
                            end
                            8'h52: begin
                                is_write <= 1'b0;
                                state    <= GET_ADDR;
                            end
                            8'h53: begin
                                if (!tpu_busy) begin
                                    tpu_start <= 1'b1;
                                    tx_data   <= ACK_BYTE;
                                end else begin
                                    tx_data   <= NAK_BYTE;
                                end
                                state <= RESP;
                            end
                            8'h3F: begin
                                tx_data <= {6'b0, tpu_done, tpu_busy};
                                state   <= RESP;
                            end
                            default: begin
                                tx_data <= NAK_BYTE;
                                state   <= RESP;
                            end
                        endcase
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        mem_addr <= rx_data;
                        state    <= GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (rx_valid) begin
                        count <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        state <= is_write ? WR_DATA : RD_FETCH;
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        mem_wdata <= rx_data;
                        mem_we    <= 1'b1;
                        count     <= count - 9'd1;
                        if (count == 9'd1) begin
                            tx_data <= ACK_BYTE;
                            state   <= RESP;
                        end
                    end
                end
                RD_FETCH: begin
                    tx_data  <= mem_rdata;
                    tx_valid <= 1'b1;
                    state    <= RD_SEND;
                end
                RD_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        mem_addr <= mem_addr + 8'd1;
                        count    <= count - 9'd1;
                        state    <= (count == 9'd1) ? IDLE : RD_FETCH;
                    end
                end
                RESP: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A byte arriving on the expiry cycle still counts as activity.
            if (timed) begin
                if (rx_valid) begin
                    timer <= '0;
                end else if (timer == TMAX) begin
                    timer       <= '0;
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
            end

            if (rx_valid && busy_tx)
                overrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder; a packet-level model predicts tx bytes, writes and start pulses.
module tb_uart_cmd_decoder;

    localparam int TO = 64;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       tpu_start;
    logic       tpu_busy = 1'b0;
    logic       tpu_done = 1'b0;
    logic       timeout_err;
    logic       overrun_err;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .tpu_start(tpu_start), .tpu_busy(tpu_busy), .tpu_done(tpu_done),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Memory seen by the DUT, plus the bench's own prediction of its contents.
    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

    logic [7:0]  tx_q[$];
    logic [15:0] we_q[$];
    int n_start = 0, n_start_busy = 0, n_timeout = 0, n_overrun = 0, n_drop = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (mem_we) we_q.push_back({mem_addr, mem_wdata});
            if (tpu_start) begin
                n_start++;
                if (tpu_busy) n_start_busy++;
            end
            if (timeout_err) n_timeout++;
            if (overrun_err) n_overrun++;
            if (prev_v && !prev_r && !tx_valid) n_drop++;
            prev_v = tx_valid;
            prev_r = tx_ready;
        end else begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end
    end

    bit rdy_mode = 1'b0;
    bit rdy_fixed = 1'b1;
    initial forever begin
        @(posedge clk); #1;
        tx_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : rdy_fixed;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t pkt, input int maxgap);
        foreach (pkt[i]) begin
            send_byte(pkt[i]);
            if (i != pkt.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int c = 0;
        while (tx_q.size() < n && c < 20000) begin
            tick();
            c++;
        end
        ok = (tx_q.size() >= n);
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        vectors++; if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
        vectors++; if ({mem_we, tpu_start, timeout_err, overrun_err} !== 4'b0) begin
            miscompares++; $display("FAIL reset_pulses: got %b expected 0000", {mem_we, tpu_start, timeout_err, overrun_err}); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_read_wrap();
        bit ok;
        tx_q.delete(); we_q.delete();
        rdy_mode = 1'b1;
        send_pkt('{8'h52, 8'hFE, 8'h03}, 2);
        wait_tx(3, ok);
        repeat (3) tick();
        vectors++; if (!ok || tx_q.size() != 3) begin miscompares++; $display("FAIL read_wrap_count: got %0d expected 3", tx_q.size()); end
        if (tx_q.size() == 3) begin
            vectors++; if (tx_q[0] !== 8'hFE) begin miscompares++; $display("FAIL read_wrap_b0: got %h expected fe", tx_q[0]); end
            vectors++; if (tx_q[1] !== 8'hFF) begin miscompares++; $display("FAIL read_wrap_b1: got %h expected ff", tx_q[1]); end
            vectors++; if (tx_q[2] !== 8'h00) begin miscompares++; $display("FAIL read_wrap_b2: got %h expected 00", tx_q[2]); end
        end
    endtask

    task automatic test_write_latency();
        bit ok;
        logic [15:0] exp_we [3];
        exp_we[0] = 16'h10AA; exp_we[1] = 16'h11BB; exp_we[2] = 16'h12CC;
        tx_q.delete(); we_q.delete();
        rdy_mode = 1'b0; rdy_fixed = 1'b0;
        tick();
        send_pkt('{8'h57, 8'h10, 8'h03, 8'hAA, 8'hBB}, 2);
        repeat (2) tick();
        send_byte(8'hCC);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h12, 8'hCC}) begin
            miscompares++; $display("FAIL last_write_strobe: got we=%b addr=%h data=%h expected 1 12 cc", mem_we, mem_addr, mem_wdata); end
        tick();
        vectors++; if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin
            miscompares++; $display("FAIL write_ack_latency: got v=%b d=%h expected 1 06", tx_valid, tx_data); end
        repeat (4) tick();
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL ack_held: got %b expected 1", tx_valid); end
        rdy_fixed = 1'b1;
        wait_tx(1, ok);
        repeat (3) tick();
        vectors++; if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            miscompares++; $display("FAIL write_ack: got %0d bytes expected one 06", tx_q.size()); end
        vectors++; if (we_q.size() != 3) begin miscompares++; $display("FAIL write_count: got %0d expected 3", we_q.size()); end
        for (int i = 0; i < 3 && i < we_q.size(); i++) begin
            vectors++; if (we_q[i] !== exp_we[i]) begin miscompares++; $display("FAIL write_%0d: got %h expected %h", i, we_q[i], exp_we[i]); end
        end
        for (int i = 0; i < 3; i++) ref_mem[exp_we[i][15:8]] = exp_we[i][7:0];
    endtask

    task automatic test_start_status();
        bit ok;
        int s0;
        logic [7:0] cmd [4];
        logic       bsy [4];
        logic [7:0] exp [4];
        int         exp_s [4];
        cmd = '{8'h53, 8'h53, 8'h3F, 8'h41};
        bsy = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{8'h06, 8'h15, 8'h02, 8'h15};
        exp_s = '{1, 0, 0, 0};
        rdy_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tpu_busy = bsy[k];
            tpu_done = 1'b1;
            tx_q.delete();
            s0 = n_start;
            send_byte(cmd[k]);
            wait_tx(1, ok);
            repeat (3) tick();
            vectors++; if (!ok || tx_q.size() != 1 || tx_q[0] !== exp[k]) begin
                miscompares++; $display("FAIL cmd_%h_resp: got %0d bytes first %h expected %h", cmd[k], tx_q.size(), ok ? tx_q[0] : 8'hxx, exp[k]); end
            vectors++; if (n_start - s0 != exp_s[k]) begin
                miscompares++; $display("FAIL cmd_%h_start: got %0d expected %0d", cmd[k], n_start - s0, exp_s[k]); end
        end
        tpu_busy = 1'b0; tpu_done = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt = 0, t0;
        tx_q.delete(); we_q.delete();
        t0 = n_timeout;
        send_pkt('{8'h57, 8'h00, 8'h02, 8'h11}, 0);
        while (!timeout_err && cnt < 4 * TO) begin
            tick();
            cnt++;
        end
        vectors++; if (cnt < TO - 1 || cnt > TO + 2) begin
            miscompares++; $display("FAIL timeout_delay: got %0d cycles expected about %0d", cnt, TO); end
        repeat (5) tick();
        vectors++; if (n_timeout - t0 != 1) begin miscompares++; $display("FAIL timeout_pulses: got %0d expected 1", n_timeout - t0); end
        vectors++; if (we_q.size() != 1 || we_q[0] !== 16'h0011) begin
            miscompares++; $display("FAIL timeout_write: got %0d writes expected one 0011", we_q.size()); end
        vectors++; if (tx_q.size() != 0) begin miscompares++; $display("FAIL timeout_no_tx: got %0d expected 0", tx_q.size()); end
        ref_mem[8'h00] = 8'h11;
        send_byte(8'h53);
        wait_tx(1, ok);
        repeat (3) tick();
        vectors++; if (!ok || tx_q[0] !== 8'h06) begin miscompares++; $display("FAIL after_timeout_start: got %0d bytes expected 06", tx_q.size()); end

        // Length byte arriving exactly on the expiry cycle keeps the packet alive.
        tx_q.delete(); we_q.delete();
        t0 = n_timeout;
        send_byte(8'h57);
        send_byte(8'h20);
        repeat (TO - 1) tick();
        send_byte(8'h01);
        send_byte(8'h5A);
        wait_tx(1, ok);
        repeat (3) tick();
        vectors++; if (n_timeout != t0) begin miscompares++; $display("FAIL edge_no_timeout: got %0d expected 0", n_timeout - t0); end
        vectors++; if (!ok || tx_q[0] !== 8'h06 || we_q.size() != 1 || we_q[0] !== 16'h205A) begin
            miscompares++; $display("FAIL edge_write: got %0d writes, %0d tx expected 205a and 06", we_q.size(), tx_q.size()); end
        ref_mem[8'h20] = 8'h5A;
    endtask

    task automatic test_overrun();
        bit ok;
        int o0, c = 0;
        tx_q.delete(); we_q.delete();
        o0 = n_overrun;
        rdy_mode = 1'b1;
        send_pkt('{8'h52, 8'h40, 8'h04}, 0);
        while (!tx_valid && c < 50) begin
            tick();
            c++;
        end
        send_byte(8'h57);
        wait_tx(4, ok);
        repeat (3) tick();
        vectors++; if (n_overrun - o0 != 1) begin miscompares++; $display("FAIL overrun_pulse: got %0d expected 1", n_overrun - o0); end
        vectors++; if (!ok || tx_q.size() != 4) begin miscompares++; $display("FAIL overrun_stream_len: got %0d expected 4", tx_q.size()); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            vectors++; if (tx_q[i] !== ref_mem[8'h40 + 8'(i)]) begin
                miscompares++; $display("FAIL overrun_stream_%0d: got %h expected %h", i, tx_q[i], ref_mem[8'h40 + 8'(i)]); end
        end
        tx_q.delete();
        send_byte(8'h53);
        wait_tx(1, ok);
        repeat (3) tick();
        vectors++; if (!ok || tx_q[0] !== 8'h06 || we_q.size() != 0) begin
            miscompares++; $display("FAIL overrun_resync: got %0d tx %0d writes expected 06 and none", tx_q.size(), we_q.size()); end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        tx_q.delete(); we_q.delete();
        send_pkt('{8'h57, 8'h30, 8'h05, 8'h01, 8'h02}, 0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        vectors++; if ({tx_data, tx_valid, mem_addr, mem_wdata, mem_we, tpu_start, timeout_err, overrun_err} !== 29'b0) begin
            miscompares++; $display("FAIL midreset_outputs: got %h expected 0",
                {tx_data, tx_valid, mem_addr, mem_wdata, mem_we, tpu_start, timeout_err, overrun_err}); end
        tick();
        rst_n = 1'b1;
        ref_mem[8'h30] = 8'h01; ref_mem[8'h31] = 8'h02;
        we_q.delete(); tx_q.delete();
        tpu_busy = 1'b1; tpu_done = 1'b0;
        repeat (2 * TO) tick();
        vectors++; if (tx_q.size() != 0) begin miscompares++; $display("FAIL midreset_silent: got %0d tx expected 0", tx_q.size()); end
        send_byte(8'h3F);
        wait_tx(1, ok);
        repeat (3) tick();
        vectors++; if (!ok || tx_q[0] !== 8'h01 || we_q.size() != 0) begin
            miscompares++; $display("FAIL midreset_idle: got %0d tx %0d writes expected status 01", tx_q.size(), we_q.size()); end
        tpu_busy = 1'b0;
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            bq_t pkt, etx;
            logic [15:0] ewe[$];
            logic [7:0] a, c, d;
            int r, len, s0, t0, o0, es;
            bit ok;
            pkt = {}; etx = {}; ewe = {};
            tpu_busy = 1'($urandom_range(0, 1));
            tpu_done = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            len = ($urandom_range(0, 15) == 0) ? 256 : $urandom_range(1, 6);
            a   = 8'($urandom);
            es  = 0;
            if (r <= 2) begin
                pkt.push_back(8'h57); pkt.push_back(a); pkt.push_back(8'(len));
                for (int i = 0; i < len; i++) begin
                    d = 8'($urandom);
                    pkt.push_back(d);
                    ewe.push_back({a + 8'(i), d});
                    ref_mem[a + 8'(i)] = d;
                end
                etx.push_back(8'h06);
            end else if (r <= 5) begin
                pkt.push_back(8'h52); pkt.push_back(a); pkt.push_back(8'(len));
                for (int i = 0; i < len; i++) etx.push_back(ref_mem[a + 8'(i)]);
            end else if (r == 6) begin
                pkt.push_back(8'h53);
                etx.push_back(tpu_busy ? 8'h15 : 8'h06);
                es = tpu_busy ? 0 : 1;
            end else if (r == 7) begin
                pkt.push_back(8'h3F);
                etx.push_back({6'b0, tpu_done, tpu_busy});
            end else begin
                do c = 8'($urandom); while (c == 8'h57 || c == 8'h52 || c == 8'h53 || c == 8'h3F);
                pkt.push_back(c);
                etx.push_back(8'h15);
            end
            tx_q.delete(); we_q.delete();
            s0 = n_start; t0 = n_timeout; o0 = n_overrun;
            send_pkt(pkt, 3);
            wait_tx(etx.size(), ok);
            repeat (3) tick();
            vectors++; if (!ok || tx_q.size() != etx.size()) begin
                miscompares++; $display("FAIL rnd%0d_tx_len: got %0d expected %0d", k, tx_q.size(), etx.size()); end
            for (int i = 0; i < etx.size() && i < tx_q.size(); i++) begin
                vectors++; if (tx_q[i] !== etx[i]) begin miscompares++; $display("FAIL rnd%0d_tx%0d: got %h expected %h", k, i, tx_q[i], etx[i]); end
            end
            vectors++; if (we_q.size() != ewe.size()) begin
                miscompares++; $display("FAIL rnd%0d_we_len: got %0d expected %0d", k, we_q.size(), ewe.size()); end
            for (int i = 0; i < ewe.size() && i < we_q.size(); i++) begin
                vectors++; if (we_q[i] !== ewe[i]) begin miscompares++; $display("FAIL rnd%0d_we%0d: got %h expected %h", k, i, we_q[i], ewe[i]); end
            end
            vectors++; if (n_start - s0 != es) begin miscompares++; $display("FAIL rnd%0d_start: got %0d expected %0d", k, n_start - s0, es); end
            vectors++; if (n_timeout != t0 || n_overrun != o0) begin
                miscompares++; $display("FAIL rnd%0d_errs: got to=%0d ov=%0d expected 0 0", k, n_timeout - t0, n_overrun - o0); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'(i);
            ref_mem[i] = 8'(i);
        end
        test_reset();
        test_read_wrap();
        test_write_latency();
        test_start_status();
        test_timeout();
        test_overrun();
        test_reset_mid_write();
        test_random(40);
        vectors++; if (n_drop != 0) begin miscompares++; $display("FAIL tx_valid_dropped: got %0d expected 0", n_drop); end
        vectors++; if (n_start_busy != 0) begin miscompares++; $display("FAIL start_while_busy: got %0d expected 0", n_start_busy); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
